// File: rtl/wb_port_arb_pkg.sv
// Shared constants and types for the register-file writeback port arbiter.
package wb_port_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_STARVED = 2'd2
   } arb_state_e;

   localparam logic [1:0] FIFO_DEPTH = 2'd2;
   localparam logic [4:0] REG_ZERO   = 5'd0;
   localparam logic       WE_ON      = 1'b1;
   localparam logic       WE_OFF     = 1'b0;

endpackage

// File: rtl/wb_pend_fifo.sv
// Two-entry in-order queue of long-unit results with same-cycle address invalidation.
module wb_pend_fifo
   import wb_port_arb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic [4:0]  push_wd,
   input  logic [31:0] push_data,
   input  logic        pop,
   input  logic        inv_en,
   input  logic [4:0]  inv_wd,
   output logic [4:0]  head_wd,
   output logic [31:0] head_data,
   output logic [1:0]  count,
   output logic [1:0]  count_next,
   output logic        inv_hit
);

   logic [1:0]                  cnt_q, cnt_d;
   logic [FIFO_DEPTH-1:0][4:0]  wd_q, wd_d;
   logic [FIFO_DEPTH-1:0][31:0] data_q, data_d;
   logic [2:0]                  c_vld, hit, keep;
   logic [2:0][4:0]             c_wd;
   logic [2:0][31:0]            c_data;
   logic [1:0]                  n;

   // Candidates in age order: head, second, incoming. Survivors are packed
   // toward slot 0; at most two survive because push requires a free slot.
   always_comb begin
      c_vld  = {push, (cnt_q == 2'd2), (cnt_q != 2'd0) && !pop};
      c_wd   = {push_wd, wd_q[1], wd_q[0]};
      c_data = {push_data, data_q[1], data_q[0]};
      hit    = '0;
      keep   = '0;
      wd_d   = '0;
      data_d = '0;
      n      = '0;
      for (int i = 0; i < 3; i++) begin
         hit[i]  = inv_en && c_vld[i] && (c_wd[i] == inv_wd);
         keep[i] = c_vld[i] && !hit[i];
         if (keep[i] && (n < FIFO_DEPTH)) begin
            wd_d[n[0]]   = c_wd[i];
            data_d[n[0]] = c_data[i];
            n            = n + 2'd1;
         end
      end
      cnt_d = n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         wd_q   <= '0;
         data_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         wd_q   <= wd_d;
         data_q <= data_d;
      end
   end

   assign head_wd    = wd_q[0];
   assign head_data  = data_q[0];
   assign count      = cnt_q;
   assign count_next = cnt_d;
   assign inv_hit    = |hit;

endmodule

// File: rtl/wb_port_arb.sv
// Arbitrates the single register-file write port between the pipeline and queued
// long-unit results; requests pipeline bubbles when queued results starve.
module wb_port_arb
   import wb_port_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  pipe_wd,
   input  logic        pipe_wreg,
   input  logic [31:0] pipe_wdata,
   input  logic        lu_valid,
   input  logic [4:0]  lu_wd,
   input  logic [31:0] lu_wdata,
   output logic        lu_ready,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        stall_req,
   output logic [1:0]  pend_cnt
);

   arb_state_e  state_q, state_d;
   logic [3:0]  blk_q, blk_d;
   logic        rf_we_q, rf_we_d;
   logic [4:0]  rf_waddr_q, rf_waddr_d;
   logic [31:0] rf_wdata_q, rf_wdata_d;
   logic        stall_q, stall_d;

   logic        push, grant_fifo, inv_en, inv_hit;
   logic [1:0]  cnt, cnt_next;
   logic [4:0]  head_wd;
   logic [31:0] head_data;

   assign lu_ready   = (cnt < FIFO_DEPTH);
   assign push       = lu_valid && lu_ready && (lu_wd != REG_ZERO);
   assign grant_fifo = !pipe_wreg && (cnt != 2'd0);
   assign inv_en     = pipe_wreg && (pipe_wd != REG_ZERO);

   wb_pend_fifo u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_wd    (lu_wd),
      .push_data  (lu_wdata),
      .pop        (grant_fifo),
      .inv_en     (inv_en),
      .inv_wd     (pipe_wd),
      .head_wd    (head_wd),
      .head_data  (head_data),
      .count      (cnt),
      .count_next (cnt_next),
      .inv_hit    (inv_hit)
   );

   always_comb begin
      rf_we_d    = WE_OFF;
      rf_waddr_d = '0;
      rf_wdata_d = '0;
      // A pipeline write to r0 still owns the port; it just does not write.
      if (pipe_wreg) begin
         if (pipe_wd != REG_ZERO) begin
            rf_we_d    = WE_ON;
            rf_waddr_d = pipe_wd;
            rf_wdata_d = pipe_wdata;
         end
      end else if (grant_fifo) begin
         rf_we_d    = WE_ON;
         rf_waddr_d = head_wd;
         rf_wdata_d = head_data;
      end

      blk_d = blk_q;
      if (grant_fifo || inv_hit || (cnt == 2'd0))
         blk_d = '0;
      else if (pipe_wreg && (blk_q != 4'hF))
         blk_d = blk_q + 4'd1;

      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (push) state_d = ST_PENDING;
         ST_PENDING: if (blk_d >= 4'(STARVE_LIMIT)) state_d = ST_STARVED;
         ST_STARVED: if (grant_fifo || inv_hit) state_d = ST_PENDING;
         default:    state_d = ST_IDLE;
      endcase
      if (cnt_next == 2'd0)
         state_d = ST_IDLE;

      stall_d = (state_d == ST_STARVED);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         blk_q      <= '0;
         rf_we_q    <= WE_OFF;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         stall_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         blk_q      <= blk_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         stall_q    <= stall_d;
      end
   end

   assign rf_we     = rf_we_q;
   assign rf_waddr  = rf_waddr_q;
   assign rf_wdata  = rf_wdata_q;
   assign stall_req = stall_q;
   assign pend_cnt  = cnt;

endmodule
